// File: rtl/pipe_scroller.sv
`default_nettype none
// pipe_scroller: scrolls three pipes, respawns them with LFSR gaps, scores and detects collisions.
// Collision/HALT is built only with PIPE_SCROLLER_COLLIDE_EN defined. Rev 1.0
module pipe_scroller #(
  parameter int unsigned HEIGHT      = 40,
  parameter int unsigned TICK_DIV    = 4,
  parameter int unsigned RESPAWN_POS = 60,
  parameter int unsigned GAP_SIZE    = 10,
  parameter int unsigned MIN_TOP     = 4,
  parameter int unsigned BIRD_SPAN   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  altitude,
  output logic [71:0] gaps,
  output logic        collide,
  output logic [7:0]  score,
  output logic        running
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  typedef logic [7:0] byte3_t [3];

  localparam byte3_t     INIT_POS    = '{8'd20, 8'd40, 8'd60};
  localparam byte3_t     INIT_MAX    = '{8'd30, 8'd25, 8'd35};
  localparam byte3_t     INIT_MIN    = '{8'd20, 8'd15, 8'd25};
  localparam logic [7:0] LFSR_SEED   = 8'hA5;
  localparam logic [7:0] C_TICK_LAST = 8'(TICK_DIV - 1);
  localparam logic [7:0] C_RESPAWN   = 8'(RESPAWN_POS);
  localparam logic [7:0] C_GAP       = 8'(GAP_SIZE);
  localparam logic [7:0] C_MIN_TOP   = 8'(MIN_TOP);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] lfsr_q, lfsr_d;
  logic [7:0] score_q, score_d;
  byte3_t     pos_q, pos_d;
  byte3_t     max_q, max_d;
  byte3_t     min_q, min_d;
  logic       hit;
  logic       tick;
  logic [1:0] n_resp;
  logic [7:0] new_min;
  logic [8:0] score_sum;

`ifdef PIPE_SCROLLER_COLLIDE_EN
  localparam logic [8:0] C_HEIGHT = 9'(HEIGHT);
  localparam logic [7:0] C_SPAN   = 8'(BIRD_SPAN);

  logic signed [8:0] bird_row;
  logic [2:0]        pipe_hit;

  // An altitude above HEIGHT gives a negative row, which lies outside every gap.
  always_comb begin
    bird_row = $signed(C_HEIGHT) - $signed({1'b0, altitude});
    for (int i = 0; i < 3; i++) begin
      pipe_hit[i] = (pos_q[i] <= C_SPAN) &&
                    !((bird_row > $signed({1'b0, min_q[i]})) &&
                      (bird_row < $signed({1'b0, max_q[i]})));
    end
    hit = (altitude == 8'd0) || (|pipe_hit);
  end

  assign collide = (state_q == S_HALT);
`else
  logic unused_cfg;
  assign unused_cfg = ^{altitude, 8'(HEIGHT), 8'(BIRD_SPAN)};
  assign hit        = 1'b0;
  assign collide    = 1'b0;
`endif

  assign new_min = C_MIN_TOP + {4'b0000, lfsr_q[3:0]};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    lfsr_d    = lfsr_q;
    score_d   = score_q;
    pos_d     = pos_q;
    max_d     = max_q;
    min_d     = min_q;
    tick      = 1'b0;
    n_resp    = 2'd0;
    score_sum = 9'd0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          cnt_d   = 8'd0;
        end
      end
      S_RUN: begin
        // A collision freezes everything on this edge, including a coincident tick.
        if (hit) begin
          state_d = S_HALT;
        end else begin
          tick  = (cnt_q == C_TICK_LAST);
          cnt_d = tick ? 8'd0 : cnt_q + 8'd1;
          if (tick) begin
            lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
            for (int i = 0; i < 3; i++) begin
              if (pos_q[i] == 8'd0) begin
                pos_d[i] = C_RESPAWN;
                min_d[i] = new_min;
                max_d[i] = new_min + C_GAP;
                n_resp   = n_resp + 2'd1;
              end else begin
                pos_d[i] = pos_q[i] - 8'd1;
              end
            end
            score_sum = {1'b0, score_q} + {7'b0000000, n_resp};
            score_d   = score_sum[8] ? 8'hFF : score_sum[7:0];
          end
        end
      end
      S_HALT: begin
        if (start) begin
          state_d = S_RUN;
          cnt_d   = 8'd0;
          score_d = 8'd0;
          pos_d   = INIT_POS;
          max_d   = INIT_MAX;
          min_d   = INIT_MIN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      lfsr_q  <= LFSR_SEED;
      score_q <= 8'd0;
      pos_q   <= INIT_POS;
      max_q   <= INIT_MAX;
      min_q   <= INIT_MIN;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lfsr_q  <= lfsr_d;
      score_q <= score_d;
      pos_q   <= pos_d;
      max_q   <= max_d;
      min_q   <= min_d;
    end
  end

  assign gaps    = {pos_q[0], max_q[0], min_q[0],
                    pos_q[1], max_q[1], min_q[1],
                    pos_q[2], max_q[2], min_q[2]};
  assign score   = score_q;
  assign running = (state_q == S_RUN);

endmodule
`default_nettype wire

// File: tb/tb_pipe_scroller.sv
`default_nettype none
// tb_pipe_scroller: randomized scoreboard bench with a behavioural world model.
// Collision expectations follow PIPE_SCROLLER_COLLIDE_EN. Rev 1.0
module tb_pipe_scroller;

  localparam int HEIGHT      = 40;
  localparam int TICK_DIV    = 4;
  localparam int RESPAWN_POS = 60;
  localparam int GAP_SIZE    = 10;
  localparam int MIN_TOP     = 4;
  localparam int BIRD_SPAN   = 8;
  localparam int NCYC        = 26000;
  localparam logic [71:0] INIT_GAPS = 72'h141E14_28190F_3C2319;

`ifdef PIPE_SCROLLER_COLLIDE_EN
  localparam bit COLLIDE_EN = 1'b1;
`else
  localparam bit COLLIDE_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  altitude = 8'd20;
  logic [71:0] gaps;
  logic        collide;
  logic [7:0]  score;
  logic        running;

  always #5 clk = ~clk;

  pipe_scroller #(
    .HEIGHT(HEIGHT), .TICK_DIV(TICK_DIV), .RESPAWN_POS(RESPAWN_POS),
    .GAP_SIZE(GAP_SIZE), .MIN_TOP(MIN_TOP), .BIRD_SPAN(BIRD_SPAN)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .altitude(altitude),
    .gaps(gaps), .collide(collide), .score(score), .running(running)
  );

  typedef struct packed {
    logic [71:0] gaps;
    logic [7:0]  score;
    logic        running;
    logic        collide;
  } obs_t;

  obs_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // World model: mode 0 = idle, 1 = run, 2 = halt.
  int m_mode, m_score, m_lfsr, m_run_cycles;
  int m_pos[3], m_min[3], m_max[3];

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_layout();
    m_pos = '{20, 40, 60};
    m_max = '{30, 25, 35};
    m_min = '{20, 15, 25};
  endfunction

  function automatic void model_reset();
    model_layout();
    m_mode = 0; m_score = 0; m_lfsr = 'hA5; m_run_cycles = 0;
  endfunction

  function automatic obs_t model_obs();
    obs_t o;
    for (int i = 0; i < 3; i++) begin
      o.gaps[71-24*i -: 24] = {8'(m_pos[i]), 8'(m_max[i]), 8'(m_min[i])};
    end
    o.score   = 8'(m_score);
    o.running = (m_mode == 1);
    o.collide = (m_mode == 2);
    return o;
  endfunction

  function automatic bit model_collides(input int alt);
    int row = HEIGHT - alt;
    if (alt == 0) return 1'b1;
    for (int i = 0; i < 3; i++)
      if (m_pos[i] <= BIRD_SPAN && !(row > m_min[i] && row < m_max[i])) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void model_tick();
    int nib = m_lfsr % 16;
    int fb  = ((m_lfsr >> 7) ^ (m_lfsr >> 5) ^ (m_lfsr >> 4) ^ (m_lfsr >> 3)) & 1;
    for (int i = 0; i < 3; i++) begin
      if (m_pos[i] == 0) begin
        m_pos[i] = RESPAWN_POS;
        m_min[i] = MIN_TOP + nib;
        m_max[i] = m_min[i] + GAP_SIZE;
        m_score  = (m_score >= 255) ? 255 : m_score + 1;
      end else begin
        m_pos[i] = m_pos[i] - 1;
      end
    end
    m_lfsr = ((m_lfsr * 2) % 256) + fb;
  endfunction

  function automatic void model_step(input bit st, input int alt);
    case (m_mode)
      0: if (st) begin m_mode = 1; m_run_cycles = 0; end
      1: begin
        if (COLLIDE_EN && model_collides(alt)) m_mode = 2;
        else begin
          if (m_run_cycles % TICK_DIV == TICK_DIV - 1) model_tick();
          m_run_cycles++;
        end
      end
      default: if (st) begin model_layout(); m_score = 0; m_run_cycles = 0; m_mode = 1; end
    endcase
  endfunction

  function automatic int safe_alt();
    for (int i = 0; i < 3; i++)
      if (m_pos[i] <= BIRD_SPAN)
        return HEIGHT - (m_min[i] + 1 + int'($urandom_range(0, m_max[i] - m_min[i] - 2)));
    return int'($urandom_range(1, HEIGHT));
  endfunction

  task automatic step_push();
    model_step(start, int'(altitude));
    exp_q.push_back(model_obs());
  endtask

  initial begin : monitor
    obs_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("gaps", gaps, 72'(e.gaps));
        chk("score", 72'(score), 72'(e.score));
        chk("running", 72'(running), 72'(e.running));
        chk("collide", 72'(collide), 72'(e.collide));
      end
    end
  end

  initial begin : driver
    bit rst_done = 1'b0;
    int r;
    model_reset();
    #1 rst_n = 1'b0;
    #2;
    chk("reset_gaps", gaps, INIT_GAPS);
    chk("reset_score", 72'(score), 72'd0);
    chk("reset_running", 72'(running), 72'd0);
    chk("reset_collide", 72'(collide), 72'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < 20; k++) begin
      step_push();
      @(negedge clk);
    end
    chk("idle_gaps", gaps, INIT_GAPS);
    chk("idle_running", 72'(running), 72'd0);

    start = 1'b1;
    step_push();
    @(negedge clk);
    start = 1'b0;
    chk("start_running", 72'(running), 72'd1);
    for (int k = 1; k <= 8; k++) begin
      step_push();
      @(negedge clk);
      if (k == 4) chk("pipe0_pos_4cyc", 72'(gaps[71:64]), 72'd19);
      if (k == 8) begin
        chk("pipe0_pos_8cyc", 72'(gaps[71:64]), 72'd18);
        chk("pipe0_bounds", 72'(gaps[63:48]), 72'h1E14);
      end
    end

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      if (!rst_done && m_mode == 1 && m_score == 3) begin
        rst_done = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_gaps", gaps, INIT_GAPS);
        chk("async_rst_score", 72'(score), 72'd0);
        chk("async_rst_running", 72'(running), 72'd0);
        chk("async_rst_collide", 72'(collide), 72'd0);
        model_reset();
        exp_q.push_back(model_obs());
        @(negedge clk);
        rst_n = 1'b1;
      end else begin
        start = ($urandom_range(0, 39) == 0);
        r = int'($urandom_range(0, 199));
        if (r == 0) altitude = 8'd0;
        else if (r < 3) altitude = 8'($urandom_range(0, 255));
        else altitude = 8'(safe_alt());
        step_push();
        @(negedge clk);
      end
    end
    start = 1'b0;
    @(negedge clk);
    chk("queue_drained", 72'(exp_q.size()), 72'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
